// File: rtl/dimmer_pkg.sv
// rtl/dimmer_pkg.sv - shared types, encodings and threshold math for pwm_dimmer_multi
//
// Optional feature macro: PWM_DIMMER_GAMMA_EN
//   defined   : quadratic brightness curve (step*step*ticks)/(num_steps-1)
//   undefined : linear brightness curve step*ticks
// In both builds the top step is fully on (threshold = period length).
package dimmer_pkg;

  typedef enum logic [1:0] {
    MANUAL       = 2'd0,
    BREATHE_UP   = 2'd1,
    BREATHE_DOWN = 2'd2
  } dimmer_state_e;

  localparam logic MODE_MANUAL  = 1'b0;
  localparam logic MODE_BREATHE = 1'b1;

  // PWM compare threshold for a brightness step within a period of len clocks.
  // len and num_steps are elaboration-time constants at every call site, so the
  // divisions fold away.
  function automatic logic [31:0] calc_thr(input logic [31:0] step,
                                           input logic [31:0] len,
                                           input logic [31:0] num_steps);
    logic [31:0] ticks;
    ticks = len / (num_steps - 32'd1);
    if (step >= num_steps - 32'd1) return len;
`ifdef PWM_DIMMER_GAMMA_EN
    return (step * step * ticks) / (num_steps - 32'd1);
`else
    return step * ticks;
`endif
  endfunction

endpackage

// File: rtl/button_sync_edge.sv
// rtl/button_sync_edge.sv - two-flop synchroniser with falling-edge pulse
//
// Ports:
//   clk        : clock
//   rst_n      : asynchronous active-low reset (all flops reset to 1 = released)
//   btn_n      : raw active-low button, asynchronous to clk
//   fall_pulse : one-cycle pulse when the synchronised level goes 1 -> 0
module button_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n,
  output logic fall_pulse
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= btn_n;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // Pulse is a gate of two flops, so it is glitch-free within the clock domain;
  // holding the button low yields exactly one pulse.
  assign fall_pulse = prev_q & ~sync2_q;

endmodule

// File: rtl/pwm_dimmer_multi.sv
// rtl/pwm_dimmer_multi.sv - multi-channel PWM LED dimmer with manual and breathe modes
//
// Optional feature macro: PWM_DIMMER_GAMMA_EN (quadratic brightness curve, see dimmer_pkg).
//
// Ports:
//   clock_50     : 50 MHz system clock, rising edge
//   clr_n        : asynchronous active-low reset
//   up_n         : brightness-up button, active-low, asynchronous
//   down_n       : brightness-down button, active-low, asynchronous
//   test         : 1 selects the short TEST_CYCLE_LEN period
//   mode         : 0 manual, 1 breathe
//   leds         : PWM outputs, all bits identical
//   stepcounter  : current brightness step
//   cyclecounter : current position within the PWM period
module pwm_dimmer_multi
  import dimmer_pkg::*;
#(
  parameter int NUM_LEDS        = 10,
  parameter int NUM_STEPS       = 16,
  parameter int STEP_W          = 4,
  parameter int CYCLE_W         = 18,
  parameter int CYCLE_LEN       = 249990,
  parameter int TEST_CYCLE_LEN  = 30,
  parameter int BREATHE_PERIODS = 4
) (
  input  logic                clock_50,
  input  logic                clr_n,
  input  logic                up_n,
  input  logic                down_n,
  input  logic                test,
  input  logic                mode,
  output logic [NUM_LEDS-1:0] leds,
  output logic [STEP_W-1:0]   stepcounter,
  output logic [CYCLE_W-1:0]  cyclecounter
);

  localparam logic [STEP_W-1:0]  STEP_MAX = STEP_W'(NUM_STEPS - 1);
  localparam logic [STEP_W-1:0]  STEP_ONE = STEP_W'(1);
  localparam logic [STEP_W-1:0]  STEP_ZERO = '0;
  localparam int                 BC_W     = (BREATHE_PERIODS > 1) ? $clog2(BREATHE_PERIODS) : 1;
  localparam logic [BC_W-1:0]    BC_LAST  = BC_W'(BREATHE_PERIODS - 1);
  localparam logic [CYCLE_W-1:0] LEN_RUN  = CYCLE_W'(CYCLE_LEN);
  localparam logic [CYCLE_W-1:0] LEN_TEST = CYCLE_W'(TEST_CYCLE_LEN);

  logic               up_pulse;
  logic               down_pulse;
  logic               test_q;
  logic               armed_q;
  logic               test_chg;
  logic               wrap;
  logic [CYCLE_W-1:0] period_last;
  logic [CYCLE_W-1:0] thr_next;
  logic [CYCLE_W-1:0] thr_q;
  dimmer_state_e      state_q;
  logic [BC_W-1:0]    bc_q;

  button_sync_edge u_up_sync (
    .clk        (clock_50),
    .rst_n      (clr_n),
    .btn_n      (up_n),
    .fall_pulse (up_pulse)
  );

  button_sync_edge u_down_sync (
    .clk        (clock_50),
    .rst_n      (clr_n),
    .btn_n      (down_n),
    .fall_pulse (down_pulse)
  );

  // armed_q masks the first edge after reset: test_q holds no real history yet,
  // so a test=1 level at release must not be mistaken for a change.
  assign test_chg    = armed_q & (test ^ test_q);
  assign period_last = test ? (LEN_TEST - 1'b1) : (LEN_RUN - 1'b1);
  // >= rather than == so a counter left beyond the short period still wraps.
  assign wrap        = ~test_chg & (cyclecounter >= period_last);
  // Threshold is evaluated against the period length that will apply next.
  assign thr_next    = test ? CYCLE_W'(calc_thr(32'(stepcounter), TEST_CYCLE_LEN, NUM_STEPS))
                            : CYCLE_W'(calc_thr(32'(stepcounter), CYCLE_LEN, NUM_STEPS));

  // Period counter, latched threshold and PWM outputs. The threshold only moves
  // at a period boundary, so a duty change never produces a runt pulse.
  always_ff @(posedge clock_50 or negedge clr_n) begin
    if (!clr_n) begin
      cyclecounter <= '0;
      thr_q        <= '0;
      leds         <= '0;
      test_q       <= 1'b0;
      armed_q      <= 1'b0;
    end else begin
      armed_q <= 1'b1;
      test_q  <= test;
      leds    <= {NUM_LEDS{cyclecounter < thr_q}};
      if (test_chg || wrap) begin
        cyclecounter <= '0;
        thr_q        <= thr_next;
      end else begin
        cyclecounter <= cyclecounter + 1'b1;
      end
    end
  end

  // Brightness state machine. A breathe step fires on every BREATHE_PERIODS-th wrap.
  always_ff @(posedge clock_50 or negedge clr_n) begin
    if (!clr_n) begin
      state_q     <= MANUAL;
      stepcounter <= '0;
      bc_q        <= '0;
    end else begin
      case (state_q)
        MANUAL: begin
          if (mode == MODE_BREATHE) begin
            state_q <= BREATHE_UP;
          end else if (up_pulse && !down_pulse && stepcounter != STEP_MAX) begin
            stepcounter <= stepcounter + 1'b1;
          end else if (down_pulse && !up_pulse && stepcounter != STEP_ZERO) begin
            stepcounter <= stepcounter - 1'b1;
          end
        end
        BREATHE_UP: begin
          if (mode == MODE_MANUAL) begin
            state_q <= MANUAL;
            bc_q    <= '0;
          end else if (wrap) begin
            if (bc_q == BC_LAST) begin
              bc_q <= '0;
              // Already at the top (breathe entered at max): turn around immediately.
              if (stepcounter >= STEP_MAX) begin
                stepcounter <= stepcounter - 1'b1;
                state_q     <= BREATHE_DOWN;
              end else begin
                stepcounter <= stepcounter + 1'b1;
                if (stepcounter == STEP_MAX - 1'b1) state_q <= BREATHE_DOWN;
              end
            end else begin
              bc_q <= bc_q + 1'b1;
            end
          end
        end
        BREATHE_DOWN: begin
          if (mode == MODE_MANUAL) begin
            state_q <= MANUAL;
            bc_q    <= '0;
          end else if (wrap) begin
            if (bc_q == BC_LAST) begin
              bc_q <= '0;
              if (stepcounter == STEP_ZERO) begin
                stepcounter <= STEP_ONE;
                state_q     <= BREATHE_UP;
              end else begin
                stepcounter <= stepcounter - 1'b1;
                if (stepcounter == STEP_ONE) state_q <= BREATHE_UP;
              end
            end else begin
              bc_q <= bc_q + 1'b1;
            end
          end
        end
        default: begin
          state_q <= MANUAL;
          bc_q    <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_dimmer_multi.sv
// tb/tb_pwm_dimmer_multi.sv - self-checking bench for pwm_dimmer_multi
module tb_pwm_dimmer_multi;

  localparam int NL = 10;
  localparam int NS = 16;
  localparam int SW = 4;
  localparam int CW = 18;
  localparam int CL = 249990;
  localparam int TL = 30;
  localparam int BP = 4;

  logic          clock_50 = 1'b0;
  logic          clr_n    = 1'b0;
  logic          up_n     = 1'b1;
  logic          down_n   = 1'b1;
  logic          test     = 1'b1;
  logic          mode     = 1'b0;
  logic [NL-1:0] leds;
  logic [SW-1:0] stepcounter;
  logic [CW-1:0] cyclecounter;

  pwm_dimmer_multi #(
    .NUM_LEDS        (NL),
    .NUM_STEPS       (NS),
    .STEP_W          (SW),
    .CYCLE_W         (CW),
    .CYCLE_LEN       (CL),
    .TEST_CYCLE_LEN  (TL),
    .BREATHE_PERIODS (BP)
  ) dut (
    .clock_50     (clock_50),
    .clr_n        (clr_n),
    .up_n         (up_n),
    .down_n       (down_n),
    .test         (test),
    .mode         (mode),
    .leds         (leds),
    .stepcounter  (stepcounter),
    .cyclecounter (cyclecounter)
  );

  always #10 clock_50 = ~clock_50;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: period position, latched threshold, brightness step and a
  // breathe direction; button presses become events scheduled two edges ahead.
  int m_cc, m_thr, m_step, m_dir, m_wraps, m_edge;
  bit m_breathe, m_led, m_armed, m_test_prev, m_up_prev, m_dn_prev;
  int q_up[$];
  int q_dn[$];

  typedef struct {
    int n_up;
    int n_down;
    int exp_step;
    int exp_on;
  } press_vec_t;

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int exp_thr(input int step, input int len);
    if (step == NS - 1) return len;
    return step * (len / (NS - 1));
  endfunction

  function automatic void model_reset();
    m_cc = 0; m_thr = 0; m_step = 0; m_dir = 1; m_wraps = 0; m_edge = 0;
    m_breathe = 0; m_led = 0; m_armed = 0; m_test_prev = 0;
    m_up_prev = 1; m_dn_prev = 1;
    q_up.delete();
    q_dn.delete();
  endfunction

  function automatic void model_step();
    int len;
    bit chg, wrap, up_ev, dn_ev;
    if (!clr_n) begin
      model_reset();
      return;
    end
    len = test ? TL : CL;
    chg = m_armed && (test != m_test_prev);
    m_armed = 1;
    m_test_prev = test;
    wrap = !chg && (m_cc >= len - 1);

    up_ev = 0;
    dn_ev = 0;
    if (q_up.size() > 0 && q_up[0] == m_edge) begin up_ev = 1; void'(q_up.pop_front()); end
    if (q_dn.size() > 0 && q_dn[0] == m_edge) begin dn_ev = 1; void'(q_dn.pop_front()); end
    if (m_up_prev && !up_n) q_up.push_back(m_edge + 2);
    if (m_dn_prev && !down_n) q_dn.push_back(m_edge + 2);
    m_up_prev = up_n;
    m_dn_prev = down_n;

    m_led = (m_cc < m_thr);
    if (chg || wrap) begin
      m_thr = exp_thr(m_step, len);
      m_cc = 0;
    end else begin
      m_cc++;
    end

    if (!m_breathe) begin
      if (mode) begin
        m_breathe = 1;
        m_dir = 1;
      end else if (up_ev && !dn_ev) begin
        if (m_step < NS - 1) m_step++;
      end else if (dn_ev && !up_ev) begin
        if (m_step > 0) m_step--;
      end
    end else if (!mode) begin
      m_breathe = 0;
      m_wraps = 0;
    end else if (wrap) begin
      m_wraps++;
      if (m_wraps == BP) begin
        m_wraps = 0;
        if (m_step + m_dir > NS - 1 || m_step + m_dir < 0) m_dir = -m_dir;
        m_step += m_dir;
        if (m_step == NS - 1) m_dir = -1;
        if (m_step == 0) m_dir = 1;
      end
    end
    m_edge++;
  endfunction

  task automatic tick();
    @(posedge clock_50);
    model_step();
    #1;
    check("leds", longint'(leds), longint'({NL{m_led}}));
    check("stepcounter", longint'(stepcounter), longint'(m_step));
    check("cyclecounter", longint'(cyclecounter), longint'(m_cc));
  endtask

  task automatic press_up();
    up_n = 1'b0; tick(); up_n = 1'b1; repeat (3) tick();
  endtask

  task automatic press_dn();
    down_n = 1'b0; tick(); down_n = 1'b1; repeat (3) tick();
  endtask

  task automatic wait_cc(input int v, input int budget);
    for (int i = 0; i < budget; i++) begin
      tick();
      if (cyclecounter == CW'(v)) return;
    end
    check("wait_cc_timeout", 0, 1);
  endtask

  task automatic wait_step(input int v, input int budget, input bit jiggle, output int cycles);
    cycles = 0;
    for (int i = 0; i < budget; i++) begin
      if (jiggle) begin
        up_n   = ($urandom_range(0, 3) != 0);
        down_n = ($urandom_range(0, 3) != 0);
      end
      tick();
      cycles++;
      if (stepcounter == SW'(v)) begin
        up_n = 1'b1;
        down_n = 1'b1;
        return;
      end
    end
    up_n = 1'b1;
    down_n = 1'b1;
    check("wait_step_timeout", 0, 1);
  endtask

  task automatic count_on(input int n, output int on);
    on = 0;
    for (int i = 0; i < n; i++) begin
      on += int'(leds[0]);
      tick();
    end
  endtask

  task automatic measure_period(output int on);
    wait_cc(0, 4 * TL);
    wait_cc(1, 4 * TL);
    count_on(TL, on);
  endtask

  initial begin
    press_vec_t vecs[6];
    int on, t1, t2, dummy;

    vecs[0] = '{n_up: 1,  n_down: 0,  exp_step: 1,  exp_on: 2};
    vecs[1] = '{n_up: 20, n_down: 0,  exp_step: 15, exp_on: 30};
    vecs[2] = '{n_up: 0,  n_down: 20, exp_step: 0,  exp_on: 0};
    vecs[3] = '{n_up: 5,  n_down: 0,  exp_step: 5,  exp_on: 10};
    vecs[4] = '{n_up: 0,  n_down: 2,  exp_step: 3,  exp_on: 6};
    vecs[5] = '{n_up: 14, n_down: 1,  exp_step: 14, exp_on: 28};

    model_reset();
    repeat (2) @(posedge clock_50);
    #1;
    check("reset_leds", longint'(leds), 0);
    check("reset_step", longint'(stepcounter), 0);
    check("reset_cc", longint'(cyclecounter), 0);
    @(negedge clock_50);
    clr_n = 1'b1;
    repeat (5) tick();

    // Button latency: low sampled at edge N, step visible after edge N+2.
    up_n = 1'b0; tick();
    check("lat_edge_n", longint'(stepcounter), 0);
    up_n = 1'b1; tick();
    check("lat_edge_n1", longint'(stepcounter), 0);
    tick();
    check("lat_edge_n2", longint'(stepcounter), 1);
    measure_period(on);
    check("first_step_on", on, 2);
    press_dn();

    for (int v = 0; v < 6; v++) begin
      repeat (vecs[v].n_up) press_up();
      repeat (vecs[v].n_down) press_dn();
      check($sformatf("vec%0d_step", v), longint'(stepcounter), vecs[v].exp_step);
      measure_period(on);
      check($sformatf("vec%0d_on", v), on, vecs[v].exp_on);
    end

    // Simultaneous up and down from step 5.
    repeat (9) press_dn();
    check("pre_both_step", longint'(stepcounter), 5);
    up_n = 1'b0; down_n = 1'b0; tick();
    up_n = 1'b1; down_n = 1'b1; repeat (4) tick();
    check("both_step", longint'(stepcounter), 5);

    // Mid-period press at step 3: current period keeps 6, next gets 8.
    repeat (2) press_dn();
    wait_cc(0, 4 * TL);
    wait_cc(1, 4 * TL);
    on = 0;
    for (int i = 0; i < TL; i++) begin
      on += int'(leds[0]);
      up_n = (cyclecounter == CW'(10)) ? 1'b0 : 1'b1;
      tick();
    end
    up_n = 1'b1;
    check("mid_press_cur_on", on, 6);
    count_on(TL, on);
    check("mid_press_next_on", on, 8);
    check("mid_press_step", longint'(stepcounter), 4);

    // Breathe: up from 0, one step per BP periods, buttons ignored.
    repeat (5) press_dn();
    mode = 1'b1;
    wait_step(1, 400, 1'b1, dummy);
    wait_step(2, 400, 1'b1, t1);
    wait_step(3, 400, 1'b1, t2);
    check("breathe_step_gap_a", t1, BP * TL);
    check("breathe_step_gap_b", t2, BP * TL);
    wait_step(15, 3000, 1'b1, dummy);
    wait_step(14, 400, 1'b1, t1);
    check("breathe_turn_gap", t1, BP * TL);
    wait_step(0, 3000, 1'b1, dummy);
    wait_step(1, 400, 1'b0, t1);
    check("breathe_bottom_gap", t1, BP * TL);
    wait_step(7, 1200, 1'b0, dummy);
    mode = 1'b0;
    repeat (300) tick();
    check("breathe_exit_hold", longint'(stepcounter), 7);

    // Asynchronous reset mid-period at step 9.
    repeat (2) press_up();
    check("pre_reset_step", longint'(stepcounter), 9);
    wait_cc(15, 4 * TL);
    #5;
    clr_n = 1'b0;
    #1;
    check("async_rst_leds", longint'(leds), 0);
    check("async_rst_step", longint'(stepcounter), 0);
    check("async_rst_cc", longint'(cyclecounter), 0);
    model_reset();
    @(negedge clock_50);
    clr_n = 1'b1;
    count_on(2 * TL, on);
    check("post_reset_on", on, 0);

    // test toggle clears the period counter on the next edge.
    wait_cc(12, 4 * TL);
    test = 1'b0; tick();
    check("test_off_cc", longint'(cyclecounter), 0);
    repeat (20) tick();
    test = 1'b1; tick();
    check("test_on_cc", longint'(cyclecounter), 0);

    // Randomised manual operation with occasional test/mode changes.
    for (int i = 0; i < 4000; i++) begin
      up_n   = ($urandom_range(0, 7) != 0);
      down_n = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 299) == 0) test = ~test;
      if ($urandom_range(0, 499) == 0) mode = ~mode;
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
